// File: rtl/trace_capture_buffer.sv
// Circular execution-trace buffer: samples CPU state under a capture filter, stops a
// programmable number of records after a PC trigger, then drains oldest-first over valid/ready.
module trace_capture_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 64,
  parameter int TS_W        = 16,
  parameter int FETCH_STAGE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic [DATA_W-1:0]                 PC,
  input  logic [DATA_W-1:0]                 instr,
  input  logic [DATA_W-1:0]                 mem_addr,
  input  logic [DATA_W-1:0]                 mem_data,
  input  logic                              mem_write,
  input  logic                              mem_read,
  input  logic [2:0]                        stage,
  input  logic [1:0]                        capture_mode,
  input  logic                              trig_pc_en,
  input  logic [DATA_W-1:0]                 trig_pc,
  input  logic [$clog2(DEPTH)-1:0]          post_count,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [TS_W+4*DATA_W+2-1:0]        rd_data,
  output logic [1:0]                        state,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              wrapped,
  output logic                              triggered
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = TS_W + 4*DATA_W + 2;
  localparam logic [AW:0]     FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRE   = 2'b01,
    POST  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t            state_reg;
  logic [AW:0]       count_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     post_cnt_reg;
  logic [TS_W-1:0]   ts_reg;
  logic              wrapped_reg;
  logic              triggered_reg;

  logic [REC_W-1:0]  mem [DEPTH];

  logic              qualifying;
  logic              capturing;
  logic              wr_en;
  logic              trigger_hit;
  logic              full;
  logic              pop;
  logic [AW-1:0]     rd_ptr;
  logic [REC_W-1:0]  wr_record;

  always_comb begin
    qualifying = 1'b0;
    case (capture_mode)
      2'b00:   qualifying = 1'b1;
      2'b01:   qualifying = (stage == 3'(FETCH_STAGE));
      2'b10:   qualifying = mem_read | mem_write;
      default: qualifying = mem_write;
    endcase
  end

  assign capturing   = (state_reg == PRE) || (state_reg == POST);
  assign wr_en       = capturing && qualifying && !arm && !rst;
  assign trigger_hit = qualifying && (!trig_pc_en || (PC == trig_pc));
  assign full        = (count_reg == FULL);
  assign wr_record   = {ts_reg, mem_write, mem_read, PC, instr, mem_addr, mem_data};

  // wr_ptr is frozen during DRAIN, so the oldest unread slot is always wr_ptr - count;
  // at count==DEPTH the low bits are zero and this lands on wr_ptr, the oldest record.
  assign rd_ptr   = wr_ptr_reg - count_reg[AW-1:0];
  assign rd_valid = (state_reg == DRAIN) && (count_reg != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  assign state     = state_reg;
  assign count     = count_reg;
  assign wrapped   = wrapped_reg;
  assign triggered = triggered_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_record;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      post_cnt_reg  <= '0;
      ts_reg        <= '0;
      wrapped_reg   <= 1'b0;
      triggered_reg <= 1'b0;
    end else if (arm) begin
      // arm wins over everything, including a pop in the same cycle
      state_reg     <= PRE;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      post_cnt_reg  <= '0;
      ts_reg        <= '0;
      wrapped_reg   <= 1'b0;
      triggered_reg <= 1'b0;
    end else begin
      case (state_reg)
        PRE: begin
          ts_reg <= ts_reg + TS_ONE;
          if (qualifying) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (full) begin
              wrapped_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_ONE;
            end
            if (trigger_hit) begin
              triggered_reg <= 1'b1;
              post_cnt_reg  <= post_count;
              state_reg     <= (post_count == '0) ? DRAIN : POST;
            end
          end
        end
        POST: begin
          ts_reg <= ts_reg + TS_ONE;
          if (qualifying) begin
            wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            post_cnt_reg <= post_cnt_reg - PTR_ONE;
            if (!full) begin
              count_reg <= count_reg + CNT_ONE;
            end
            if (post_cnt_reg == PTR_ONE) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (count_reg == '0) begin
            state_reg <= IDLE;
          end else if (pop) begin
            count_reg <= count_reg - CNT_ONE;
            if (count_reg == CNT_ONE) begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer (DEPTH=8): a per-cycle vector table for the
// basic trigger/drain flow plus hand sequences for wrap, filtering, stalls, reset and re-arm.
module tb_trace_capture_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int AW    = 3;
  localparam int RW    = TS_W + 4*DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [DW-1:0] PC;
  logic [DW-1:0] instr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_write;
  logic          mem_read;
  logic [2:0]    stage;
  logic [1:0]    capture_mode;
  logic          trig_pc_en;
  logic [DW-1:0] trig_pc;
  logic [AW-1:0] post_count;
  logic          rd_valid;
  logic          rd_ready;
  logic [RW-1:0] rd_data;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          wrapped;
  logic          triggered;

  always #5 clk = ~clk;

  trace_capture_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TS_W), .FETCH_STAGE(0)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .PC(PC), .instr(instr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_write(mem_write), .mem_read(mem_read), .stage(stage),
    .capture_mode(capture_mode), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .post_count(post_count), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .count(count), .wrapped(wrapped), .triggered(triggered)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          arm;
    logic [DW-1:0] pc;
    logic          rdy;
    logic [1:0]    st;
    logic [AW:0]   cnt;
    logic          vld;
    logic [RW-1:0] data;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rec(input logic [15:0] ts, input logic mw,
                                        input logic mr, input logic [15:0] pc);
    logic [15:0] ins;
    logic [15:0] adr;
    logic [15:0] dat;
    ins = ~pc;
    adr = pc + 16'h1000;
    dat = pc ^ 16'h00ff;
    return {ts, mw, mr, pc, ins, adr, dat};
  endfunction

  task automatic set_cpu(input logic [15:0] pc, input logic mw, input logic mr);
    PC        = pc;
    instr     = ~pc;
    mem_addr  = pc + 16'h1000;
    mem_data  = pc ^ 16'h00ff;
    mem_write = mw;
    mem_read  = mr;
  endtask

  task automatic pop_one(input string name, input logic [RW-1:0] exp);
    chk({name, "_valid"}, RW'(rd_valid), RW'(1'b1));
    chk({name, "_data"}, rd_data, exp);
    $display("pop %s ts=%0d pc=%h", name, rd_data[RW-1 -: TS_W], rd_data[4*DW-1 -: DW]);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic arm_and_feed(input int n);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_cpu(16'(i), 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; rd_ready = 1'b0; stage = 3'd0;
    capture_mode = 2'b00; trig_pc_en = 1'b0; trig_pc = '0; post_count = '0;
    set_cpu(16'd0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset_state", RW'(state), '0);
    chk("reset_count", RW'(count), '0);
    chk("reset_valid", RW'(rd_valid), '0);
    chk("reset_data", rd_data, '0);
    chk("reset_trig", RW'(triggered), '0);
    chk("reset_wrap", RW'(wrapped), '0);

    // T1: trigger on first record, 3 post records, then full drain
    tv[0] = '{1'b1, 16'd99, 1'b0, 2'd1, 4'd0, 1'b0, '0};
    tv[1] = '{1'b0, 16'd0,  1'b0, 2'd2, 4'd1, 1'b0, '0};
    tv[2] = '{1'b0, 16'd1,  1'b0, 2'd2, 4'd2, 1'b0, '0};
    tv[3] = '{1'b0, 16'd2,  1'b0, 2'd2, 4'd3, 1'b0, '0};
    tv[4] = '{1'b0, 16'd3,  1'b0, 2'd3, 4'd4, 1'b1, rec(16'd0, 1'b0, 1'b0, 16'd0)};
    tv[5] = '{1'b0, 16'd50, 1'b1, 2'd3, 4'd3, 1'b1, rec(16'd1, 1'b0, 1'b0, 16'd1)};
    tv[6] = '{1'b0, 16'd51, 1'b1, 2'd3, 4'd2, 1'b1, rec(16'd2, 1'b0, 1'b0, 16'd2)};
    tv[7] = '{1'b0, 16'd52, 1'b1, 2'd3, 4'd1, 1'b1, rec(16'd3, 1'b0, 1'b0, 16'd3)};
    tv[8] = '{1'b0, 16'd53, 1'b1, 2'd0, 4'd0, 1'b0, '0};
    tv[9] = '{1'b0, 16'd7,  1'b0, 2'd0, 4'd0, 1'b0, '0};

    capture_mode = 2'b00; trig_pc_en = 1'b0; post_count = 3'd3;
    for (int i = 0; i < 10; i++) begin
      arm = tv[i].arm;
      rd_ready = tv[i].rdy;
      set_cpu(tv[i].pc, 1'b0, 1'b0);
      tick();
      $display("t1 vec %0d state=%0d count=%0d valid=%0d", i, state, count, rd_valid);
      chk($sformatf("t1_state_%0d", i), RW'(state), RW'(tv[i].st));
      chk($sformatf("t1_count_%0d", i), RW'(count), RW'(tv[i].cnt));
      chk($sformatf("t1_valid_%0d", i), RW'(rd_valid), RW'(tv[i].vld));
      chk($sformatf("t1_data_%0d", i), rd_data, tv[i].data);
    end
    arm = 1'b0; rd_ready = 1'b0;

    // T2: PC trigger late enough to wrap the buffer
    trig_pc_en = 1'b1; trig_pc = 16'd20; post_count = 3'd2;
    arm = 1'b1; tick(); arm = 1'b0;
    begin
      int n = 0;
      while (state != 2'd3 && n < 100) begin
        set_cpu(16'(n), 1'b0, 1'b0);
        tick();
        n++;
      end
    end
    chk("t2_reach_drain", RW'(state), RW'(2'd3));
    chk("t2_wrapped", RW'(wrapped), RW'(1'b1));
    chk("t2_count", RW'(count), RW'(4'd8));
    chk("t2_triggered", RW'(triggered), RW'(1'b1));
    for (int k = 0; k < 8; k++) begin
      pop_one($sformatf("t2_pop%0d", k), rec(16'(15 + k), 1'b0, 1'b0, 16'(15 + k)));
    end
    chk("t2_idle", RW'(state), '0);
    chk("t2_valid_low", RW'(rd_valid), '0);

    // T3: write-only filter; a read pulse at ts 3 must be ignored
    capture_mode = 2'b11; trig_pc_en = 1'b0; post_count = 3'd2;
    arm = 1'b1; tick(); arm = 1'b0;
    begin
      int t = 0;
      while (state != 2'd3 && t < 50) begin
        set_cpu(16'h40 + 16'(t), (t == 2) || (t == 5) || (t == 9), (t == 3));
        tick();
        t++;
      end
    end
    set_cpu(16'h0, 1'b0, 1'b0);
    chk("t3_reach_drain", RW'(state), RW'(2'd3));
    chk("t3_count", RW'(count), RW'(4'd3));
    chk("t3_wrapped", RW'(wrapped), '0);
    pop_one("t3_pop0", rec(16'd2, 1'b1, 1'b0, 16'h42));
    pop_one("t3_pop1", rec(16'd5, 1'b1, 1'b0, 16'h45));
    pop_one("t3_pop2", rec(16'd9, 1'b1, 1'b0, 16'h49));
    chk("t3_idle", RW'(state), '0);

    // T4: consumer stalls mid-drain
    capture_mode = 2'b00; trig_pc_en = 1'b0; post_count = 3'd3;
    arm_and_feed(4);
    chk("t4_drain", RW'(state), RW'(2'd3));
    pop_one("t4_pop0", rec(16'd0, 1'b0, 1'b0, 16'd0));
    for (int s = 0; s < 3; s++) begin
      set_cpu(16'(77 + s), 1'b1, 1'b1);
      tick();
      chk($sformatf("t4_hold_valid_%0d", s), RW'(rd_valid), RW'(1'b1));
      chk($sformatf("t4_hold_data_%0d", s), rd_data, rec(16'd1, 1'b0, 1'b0, 16'd1));
      chk($sformatf("t4_hold_count_%0d", s), RW'(count), RW'(4'd3));
    end
    pop_one("t4_pop1", rec(16'd1, 1'b0, 1'b0, 16'd1));
    pop_one("t4_pop2", rec(16'd2, 1'b0, 1'b0, 16'd2));
    pop_one("t4_pop3", rec(16'd3, 1'b0, 1'b0, 16'd3));
    chk("t4_idle", RW'(state), '0);
    chk("t4_data_zero", rd_data, '0);

    // T5: reset while in POST
    arm_and_feed(2);
    chk("t5_in_post", RW'(state), RW'(2'd2));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_state", RW'(state), '0);
    chk("t5_count", RW'(count), '0);
    chk("t5_valid", RW'(rd_valid), '0);
    chk("t5_trig", RW'(triggered), '0);

    // T6: arm coincides with a drain handshake
    arm_and_feed(4);
    chk("t6_drain", RW'(state), RW'(2'd3));
    arm = 1'b1; rd_ready = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
    chk("t6_state", RW'(state), RW'(2'd1));
    chk("t6_count", RW'(count), '0);
    chk("t6_valid", RW'(rd_valid), '0);
    chk("t6_trig", RW'(triggered), '0);
    set_cpu(16'd5, 1'b0, 1'b0);
    tick();
    chk("t6_recapture_count", RW'(count), RW'(4'd1));
    chk("t6_recapture_state", RW'(state), RW'(2'd2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
